// File: rtl/mux_scan_sequencer_if.sv
// mux_scan_sequencer_if
//   Bundles the command, mux-side and result signals of mux_scan_sequencer.
//   Macro MUX_SCAN_AUTO_EN adds the auto_mode request line.
//   Signals:
//     start    requester -> sequencer  request a scan
//     abort    requester -> sequencer  cancel a scan in progress
//     auto_mode requester -> sequencer restart from DONE (MUX_SCAN_AUTO_EN only)
//     ch_mask  requester -> sequencer  per-channel enable, latched on accept
//     s_out    sequencer -> mux        channel select
//     y_in     mux -> sequencer        selected bit
//     busy     sequencer -> requester  scan in progress
//     done     sequencer -> requester  one-cycle completion pulse
//     data_out sequencer -> requester  last completed snapshot
//   Modports: master = requester/mux side, slave = the sequencer.
interface mux_scan_sequencer_if #(
    parameter int NUM_CH = 16,
    parameter int SEL_W  = 4
);
    logic              start;
    logic              abort;
`ifdef MUX_SCAN_AUTO_EN
    logic              auto_mode;
`endif
    logic [NUM_CH-1:0] ch_mask;
    logic [SEL_W-1:0]  s_out;
    logic              y_in;
    logic              busy;
    logic              done;
    logic [NUM_CH-1:0] data_out;

    modport master (
        output start,
        output abort,
`ifdef MUX_SCAN_AUTO_EN
        output auto_mode,
`endif
        output ch_mask,
        input  s_out,
        output y_in,
        input  busy,
        input  done,
        input  data_out
    );

    modport slave (
        input  start,
        input  abort,
`ifdef MUX_SCAN_AUTO_EN
        input  auto_mode,
`endif
        input  ch_mask,
        output s_out,
        input  y_in,
        output busy,
        output done,
        output data_out
    );
endinterface

// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer
//   Steps the select of an external NUM_CH:1 bit mux across the enabled
//   channels, holds each select for SETTLE+1 cycles, samples the mux output
//   on the last of those cycles and publishes the assembled word on done.
//   Optional macro MUX_SCAN_AUTO_EN: bus.auto_mode restarts a scan from DONE
//   with the already latched mask.
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    mux_scan_sequencer_if.slave (start/abort/ch_mask in,
//            s_out/busy/done/data_out out, y_in from the mux)
module mux_scan_sequencer #(
    parameter int NUM_CH = 16,
    parameter int SEL_W  = 4,
    parameter int SETTLE = 1
) (
    input logic                 clk,
    input logic                 rst_n,
    mux_scan_sequencer_if.slave bus
);
    localparam int              CNT_W     = 4;
    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [SEL_W-1:0]  ch_q, ch_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [NUM_CH-1:0] mask_q, mask_d;
    logic [NUM_CH-1:0] shadow_q, shadow_d;
    logic [NUM_CH-1:0] data_q, data_d;

    logic [NUM_CH-1:0] first_src;
    logic [SEL_W:0]    first_hit;   // {found, index}
    logic [SEL_W:0]    next_hit;    // {found, index}
    logic [SEL_W:0]    next_lo;
    logic              launch;
    logic              auto_go;

    // Lowest set bit of m at or above lo; MSB of the result flags a hit.
    function automatic logic [SEL_W:0] find_from(input logic [NUM_CH-1:0] m,
                                                 input logic [SEL_W:0]    lo);
        logic [SEL_W:0] r;
        r = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (m[i] && ((SEL_W+1)'(i) >= lo))
                r = {1'b1, SEL_W'(i)};
        end
        return r;
    endfunction

`ifdef MUX_SCAN_AUTO_EN
    assign auto_go = bus.auto_mode & ~bus.abort;
`else
    assign auto_go = 1'b0;
`endif

    // A fresh scan searches the live mask from IDLE, the latched one from DONE.
    assign first_src = (state_q == S_IDLE) ? bus.ch_mask : mask_q;
    assign first_hit = find_from(first_src, '0);
    assign next_lo   = {1'b0, ch_q} + {{SEL_W{1'b0}}, 1'b1};
    assign next_hit  = find_from(mask_q, next_lo);

    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        cnt_d    = cnt_q;
        mask_d   = mask_q;
        shadow_d = shadow_q;
        data_d   = data_q;
        launch   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.abort) begin
                    launch = 1'b1;
                    mask_d = bus.ch_mask;
                end
            end
            S_WAIT: begin
                if (bus.abort) begin
                    state_d = S_IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (ch_q == SEL_W'(i))
                            shadow_d[i] = bus.y_in;
                    end
                    if (next_hit[SEL_W]) begin
                        ch_d  = next_hit[SEL_W-1:0];
                        cnt_d = SETTLE_LD;
                    end else begin
                        // Publish including the bit sampled on this same edge.
                        state_d = S_DONE;
                        data_d  = shadow_d;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                if (auto_go)
                    launch = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        if (launch) begin
            shadow_d = '0;
            cnt_d    = SETTLE_LD;
            if (first_hit[SEL_W]) begin
                state_d = S_WAIT;
                ch_d    = first_hit[SEL_W-1:0];
            end else begin
                // Empty mask: straight to DONE with an all-zero snapshot.
                state_d = S_DONE;
                data_d  = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            ch_q     <= '0;
            cnt_q    <= '0;
            mask_q   <= '0;
            shadow_q <= '0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            ch_q     <= ch_d;
            cnt_q    <= cnt_d;
            mask_q   <= mask_d;
            shadow_q <= shadow_d;
            data_q   <= data_d;
        end
    end

    assign bus.s_out    = (state_q == S_WAIT) ? ch_q : '0;
    assign bus.busy     = (state_q != S_IDLE);
    assign bus.done     = (state_q == S_DONE);
    assign bus.data_out = data_q;
endmodule

// File: doc/mux_scan_sequencer.md
Name: mux_scan_sequencer

Overview:
- Sequencer that drives the select of a 16:1 bit multiplexer and samples the selected bit on each channel.
- Assembles the samples into one parallel word.
- Sits on both sides of the mux: s_out feeds the mux select, y_in consumes the mux output.
- Used wherever a multiplexed bank of single-bit inputs must be read out as a snapshot word on command.

Parameters:
- NUM_CH, 16, number of channels scanned; legal range 2..2**SEL_W.
- SEL_W, 4, select width driven to the mux.
- SETTLE, 1, extra cycles to hold each select value before sampling; legal range 0..15.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request a scan; accepted only in IDLE.
- abort  in  1  synchronous cancel of a scan in progress.
- ch_mask  in  NUM_CH  per-channel enable, latched when start is accepted.
- s_out  out  SEL_W  select to the mux.
- y_in  in  1  mux output, the bit for the current s_out.
- busy  out  1  high from the cycle after start acceptance until DONE exits.
- done  out  1  one-cycle pulse; data_out is valid from this cycle.
- data_out  out  NUM_CH  last completed snapshot; bit i = sample of channel i.

Behaviour:
- Reset (async, rst_n=0): s_out=0, busy=0, done=0, data_out=0, internal shadow word=0, FSM=IDLE, mask latch=0.
- States:
  - IDLE: s_out=0, busy=0. start=1 latches ch_mask, clears the shadow word and loads the settle counter with SETTLE. Next state is WAIT at the lowest set mask bit, or DONE if the mask is 0.
  - WAIT: s_out=current channel. Hold for SETTLE+1 cycles total. On the rising edge ending the last cycle, shadow[ch]<=y_in. Then either go to the next higher set mask bit (counter reloaded) or go to DONE if none remains.
  - DONE: one cycle. data_out<=shadow on entry so it is visible during DONE. done=1, busy=1. Next state IDLE.
- Skipping: masked-off channels take zero cycles; their shadow bits are 0. The next-channel search is combinational over the latched mask.
- Latency: from the start-accepting edge to done high = popcount(mask)*(SETTLE+1) + 1 cycles (mask=0 gives 1).
- start while busy: ignored, no queuing.
- abort=1 in WAIT: next state IDLE. No done pulse; data_out keeps its previous value; s_out returns to 0.
- abort in IDLE/DONE: no effect. abort and start together in IDLE: abort wins, nothing is accepted.
- ch_mask changes during a scan have no effect.
- data_out changes only on DONE entry or reset.
- rst_n asserted mid-scan: immediate return to the reset values above; no done.

Optional Feature:
- Macro MUX_SCAN_AUTO_EN.
- Defined: adds input port auto_mode (1 bit, after abort).
  - If auto_mode=1 during DONE, the next state is WAIT/DONE (per the same rules as start), reusing the latched mask. busy stays high; ch_mask is not re-latched.
  - abort ends auto mode exactly as above.
- Undefined: port absent; DONE always returns to IDLE.

Test Plan:
- Full mask: SETTLE=1, mux d=16'hA5C3, ch_mask=16'hFFFF, pulse start. Required: s_out steps 0..15, each held 2 cycles; done at +33 cycles; data_out=16'hA5C3; busy low the cycle after done.
- Sparse mask: d=16'hFFFF, ch_mask=16'h00F0. Required: s_out visits only 4,5,6,7; done at +9 cycles; data_out=16'h00F0.
- Empty mask: ch_mask=0. Required: done at +1 cycle, data_out=16'h0000, s_out stays 0.
- Abort: start a full scan with d=16'h1234 after a prior snapshot of 16'hA5C3; abort at cycle 5. Required: busy low the next cycle, no done, data_out stays 16'hA5C3. A second start completes with 16'h1234.
- Reset and ignored start: start pulsed again at cycle 3 of a scan is ignored (done still at +33). rst_n low at cycle 10 of a scan forces all outputs 0 asynchronously; no done after release.
- Auto mode (MUX_SCAN_AUTO_EN): auto_mode=1, ch_mask=16'h0003, SETTLE=0. Required: done every 3 cycles, busy stays high. Change d between scans and check each data_out tracks it. Drop auto_mode and the scan returns to IDLE after the next done.
